// File: rtl/demux4_pkg.sv
// Shared constants and slot state type for the 1-to-4 buffered store demux.
package demux4_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
endpackage

// File: rtl/demux4_buf_if.sv
// Input stream plus four output channels of demux4_buf; slave = the demux, master = its environment.
interface demux4_buf_if
  import demux4_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [WIDTH-1:0]        in_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic                    busy;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry holding register with full flag; 1-cycle write-to-valid latency.
// Write and read in the same cycle replaces the word without a bubble.
module demux_slot
  import demux4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  slot_state_e state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (wr_en) state <= SLOT_FULL;
        SLOT_FULL:  if (rd_ready && !wr_en) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      // data is kept (not cleared) on drain; only a write changes it
      if (wr_en) data <= wr_data;
    end
  end

  assign valid = (state == SLOT_FULL);
endmodule

// File: rtl/demux4_buf.sv
// 1-to-4 buffered demux: one-entry slot per channel, 1-cycle latency, in_ready drops only when the
// selected slot is full and not draining. Optional per-channel drain counters under DEMUX4_CNT_EN.
module demux4_buf
  import demux4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  demux4_buf_if.slave       bus
`ifdef DEMUX4_CNT_EN
  ,
  input  logic [SEL_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0]  cnt_out
`endif
);
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [NUM_CH];
  logic              accept;

  // a full slot can still take a word in the cycle it drains
  assign bus.in_ready = !valid_q[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign wr_en[k] = accept && (bus.in_sel == SEL_W'(k));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_en[k]),
      .wr_data  (bus.in_data),
      .rd_ready (bus.out_ready[k]),
      .valid    (valid_q[k]),
      .data     (data_q[k])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NUM_CH; k++) bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
  end

  assign bus.out_valid = valid_q;
  assign bus.busy      = |valid_q;

`ifdef DEMUX4_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_CH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (valid_q[k] && bus.out_ready[k]) cnt[k] <= cnt[k] + CNT_W'(1);
    end
  end

  assign cnt_out = cnt[cnt_sel];
`endif
endmodule

// File: tb/tb_demux4_buf.sv
// Directed bench for demux4_buf with a per-channel occupancy model checked every negedge.
module tb_demux4_buf;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  demux4_buf_if #(.WIDTH(W)) bus ();

`ifdef DEMUX4_CNT_EN
  logic [1:0]  cnt_sel;
  logic [15:0] cnt_out;
  demux4_buf #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus), .cnt_sel(cnt_sel), .cnt_out(cnt_out));
`else
  demux4_buf #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model: does channel k hold a word, and which one
  bit        m_full [4];
  logic [31:0] m_data [4];
  int        m_cnt  [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = '0;
        m_cnt[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        bit room, acc, drn;
        room = !m_full[k] || bus.out_ready[k];
        acc  = bus.in_valid && (int'(bus.in_sel) == k) && room;
        drn  = m_full[k] && bus.out_ready[k];
        if (drn) m_cnt[k] = (m_cnt[k] + 1) % 65536;
        if (acc) begin
          m_full[k] = 1'b1;
          m_data[k] = bus.in_data;
        end else if (drn) begin
          m_full[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0]   ev;
      logic [127:0] ed;
      for (int k = 0; k < 4; k++) begin
        ev[k] = m_full[k];
        ed[k*32 +: 32] = m_data[k];
      end
      check("out_valid", 128'(bus.out_valid), 128'(ev));
      check("out_data", bus.out_data, ed);
      check("busy", 128'(bus.busy), 128'(|ev));
      check("in_ready", 128'(bus.in_ready),
            128'(!m_full[bus.in_sel] || bus.out_ready[bus.in_sel]));
`ifdef DEMUX4_CNT_EN
      check("cnt_out", 128'(cnt_out), 128'(m_cnt[cnt_sel]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  initial begin
    rstn = 1'b0;
`ifdef DEMUX4_CNT_EN
    cnt_sel = 2'd0;
`endif
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    tick();
    tick();
    chk_en = 1'b1;

    // reset release
    rstn = 1'b1;
    drive(1'b0, 2'd2, 32'hDEADBEEF, 4'b0000);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'h0);
    check("rst_busy", 128'(bus.busy), 128'h0);
    check("rst_in_ready", 128'(bus.in_ready), 128'h1);
    check("rst_out_data", bus.out_data, 128'h0);

    // single transfer to channel 1, hold, then drain
    drive(1'b1, 2'd1, 32'h12345678, 4'b0000);
    tick();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    check("single_valid", 128'(bus.out_valid), 128'h2);
    check("single_data", 128'(bus.out_data[63:32]), 128'h12345678);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_data", 128'(bus.out_data[63:32]), 128'h12345678);
    end
    bus.out_ready = 4'b0010;
    tick();
    bus.out_ready = 4'b0000;
    check("drain_valid", 128'(bus.out_valid), 128'h0);

    // backpressure on channel 3 does not stall channel 0
    drive(1'b1, 2'd3, 32'hAAAA0003, 4'b0000);
    tick();
    drive(1'b1, 2'd3, 32'hBBBB0003, 4'b0000);
    #1;
    check("bp_in_ready3", 128'(bus.in_ready), 128'h0);
    tick();
    check("bp_no_overwrite", 128'(bus.out_data[127:96]), 128'hAAAA0003);
    drive(1'b1, 2'd0, 32'h00000055, 4'b0000);
    #1;
    check("bp_in_ready0", 128'(bus.in_ready), 128'h1);
    tick();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    check("bp_valid", 128'(bus.out_valid), 128'h9);
    check("bp_data0", 128'(bus.out_data[31:0]), 128'h55);
    check("bp_data3", 128'(bus.out_data[127:96]), 128'hAAAA0003);
    bus.out_ready = 4'b1111;
    tick();

    // simultaneous drain and accept on channel 2
    drive(1'b1, 2'd2, 32'h11111111, 4'b0000);
    tick();
    drive(1'b1, 2'd2, 32'h22222222, 4'b0100);
    #1;
    check("sim_in_ready", 128'(bus.in_ready), 128'h1);
    tick();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    check("sim_valid", 128'(bus.out_valid), 128'h4);
    check("sim_data", 128'(bus.out_data[95:64]), 128'h22222222);

    // mixed patterns, checked by the model only
    for (int i = 0; i < 40; i++) begin
      drive(1'((i % 3) != 2), 2'((i * 7) % 4), 32'h5000_0000 + 32'(i), 4'((i * 5) % 16));
      tick();
    end

    // fill all channels, then reset mid-operation
    drive(1'b0, 2'd0, 32'h0, 4'b1111);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 32'hC0 + 32'(k), 4'b0000);
      tick();
    end
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    check("fill_valid", 128'(bus.out_valid), 128'hF);
    check("fill_data", bus.out_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midrst_valid", 128'(bus.out_valid), 128'h0);
    check("midrst_busy", 128'(bus.busy), 128'h0);

`ifdef DEMUX4_CNT_EN
    cnt_sel = 2'd1;
    #1;
    check("cnt_after_rst", 128'(cnt_out), 128'h0);
    drive(1'b1, 2'd1, 32'h1, 4'b0000);
    tick();
    drive(1'b1, 2'd1, 32'h2, 4'b0010);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, 2'd1, 32'h0, 4'b0000);
    #1;
    check("cnt1_five", 128'(cnt_out), 128'h5);
    cnt_sel = 2'd0;
    #1;
    check("cnt0_zero", 128'(cnt_out), 128'h0);
    cnt_sel = 2'd1;
    drive(1'b1, 2'd1, 32'h3, 4'b0010);
    for (int i = 0; i < 65530; i++) tick();
    drive(1'b0, 2'd1, 32'h0, 4'b0010);
    tick();
    bus.out_ready = 4'b0000;
    #1;
    check("cnt1_wrap", 128'(cnt_out), 128'h0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux4_buf.md
Name: demux4_buf

Overview:
- 1-to-4 buffered demultiplexer: the write-side counterpart of the 4-1 source-select mux in the CPU datapath.
- Accepts one valid/ready input stream tagged with a 2-bit destination and delivers each word to one of four independent output channels.
- Each channel has a one-entry holding register.
- Used as the MMIO store dispatcher between the MEM stage and four peripheral write ports (LED, segment display, UART-TX, timer).

Parameters:
- WIDTH, 32, data width of input and of each output channel

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rstn  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- in_sel  input  2  destination channel 0..3
- in_data  input  WIDTH  input word
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: channel k consumer accepts this cycle
- out_data  output  4*WIDTH  channel k word on bits [k*WIDTH +: WIDTH]
- busy  output  1  OR of out_valid
- cnt_sel  input  2  (DEMUX4_CNT_EN only) counter select
- cnt_out  output  16  (DEMUX4_CNT_EN only) selected channel transfer count

Behaviour:
- Reset (rstn=0 at a rising edge):
  - all slots EMPTY; out_valid=0, busy=0.
  - every out_data slice = 0; counters = 0.
  - Reset mid-operation discards buffered words without handshake.
- Per-channel FSM, two states:
  - EMPTY -> FULL on accept to k.
  - FULL -> EMPTY on drain of k with no accept to k.
  - FULL -> FULL (data replaced) on drain and accept to k in the same cycle.
  - EMPTY -> EMPTY otherwise.
- Definitions:
  - drain_k = out_valid[k] & out_ready[k].
  - accept_k = in_valid & in_ready & (in_sel==k).
- in_ready:
  - in_ready = !full[in_sel] | out_ready[in_sel].
  - Combinational from in_sel and out_ready.
  - Valid regardless of in_valid.
  - No dependency on in_data.
- Latency: a word accepted at edge N appears on out_valid/out_data of its channel after edge N (one cycle). There is no combinational in->out path.
- Holding:
  - While out_valid[k]=1 and out_ready[k]=0, the out_data slice for k is stable.
  - out_data slice k is undefined-but-stable (last value) while out_valid[k]=0; keep the register, no clearing.
- Independence:
  - Channels drain concurrently.
  - A full channel never stalls accepts to other channels.
  - No ordering guarantee across channels; order within a channel is preserved trivially (depth 1).
- in_valid=0: no state change except drains.
- in_sel changes while in_valid=0 or in_ready=0 are legal; only the accept cycle's in_sel is used.
- busy = |out_valid, registered-derived (no combinational input path).

Optional Feature:
- Macro DEMUX4_CNT_EN.
- Defined:
  - four 16-bit counters, counter k increments on each drain_k.
  - Wraps 0xFFFF->0x0000.
  - cnt_out = counter[cnt_sel] combinationally.
  - Cleared by reset.
- Undefined: counters, cnt_sel and cnt_out ports are absent; the rest of the behaviour is identical.

Decomposition:
- Package demux4_pkg:
  - NUM_CH=4, SEL_W=2, CNT_W=16.
  - Slot state enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module demux_slot: one-entry holding register plus full flag.
  - Ports: clk, rstn, wr_en, wr_data, rd_ready, valid, data.
  - demux4_buf instantiates it NUM_CH times via generate.

Test Plan:
- Reset check: rstn=0 for 2 cycles with in_valid=1, in_sel=2, in_data=0xDEADBEEF -> out_valid=4'b0000, busy=0, in_ready=1, all out_data=0 after release.
- Single transfer: in_valid=1, in_sel=1, in_data=0x12345678, out_ready=4'b0000 for one cycle -> next cycle out_valid=4'b0010, out_data slice1=0x12345678; hold 3 cycles stable; out_ready[1]=1 -> out_valid=0 next cycle.
- Backpressure: channel 3 FULL with 0xAAAA0003, out_ready[3]=0, in_sel=3 -> in_ready=0, no overwrite. Switch in_sel=0 with 0x00000055 -> in_ready=1 and channel 0 fills while channel 3 still holds 0xAAAA0003.
- Simultaneous drain+accept: channel 2 FULL with 0x11111111, out_ready[2]=1, in_valid=1, in_sel=2, in_data=0x22222222 -> in_ready=1; next cycle out_valid[2]=1, data 0x22222222, no bubble.
- Reset mid-operation: fill channels 0..3 with 0xC0..0xC3, then rstn=0 one cycle -> out_valid=0, busy=0 at next cycle; no drain counted.
- DEMUX4_CNT_EN:
  - drain channel 1 five times -> cnt_sel=1 gives cnt_out=5; cnt_sel=0 gives 0.
  - preload via 65536 drains -> cnt_out wraps to 0.
